// File: rtl/job_launcher.sv
// Batch controller for the go/kill/done job engine: launches up to 15 jobs,
// kills on timeout or abort, and reports per-batch success/timeout counts.
module job_launcher #(
   parameter int JOB_W    = 4,
   parameter int TMO_W    = 8,
   parameter int KILL_CYC = 2,
   parameter int GAP_CYC  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [JOB_W-1:0] num_jobs,
   input  logic [TMO_W-1:0] timeout,
   input  logic             abort,
   input  logic             done,
   output logic             go,
   output logic             kill,
   output logic             busy,
   output logic             all_done,
   output logic [JOB_W-1:0] ok_cnt,
   output logic [JOB_W-1:0] tmo_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_KILL,
      S_GAP,
      S_COMPLETE
   } state_t;

   localparam int PH_MAX = (KILL_CYC > GAP_CYC) ? KILL_CYC : GAP_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [PH_W-1:0] KILL_LAST = PH_W'(KILL_CYC - 1);
   localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYC - 1);

   state_t           r_state;
   state_t           w_next;
   logic [JOB_W-1:0] r_left;
   logic [JOB_W-1:0] r_ok_cnt;
   logic [JOB_W-1:0] r_tmo_cnt;
   logic [TMO_W-1:0] r_tmo_lat;
   logic [TMO_W-1:0] r_wait_cnt;
   logic [PH_W-1:0]  r_phase;
   logic             r_go;
   logic             r_kill;
   logic             r_busy;
   logic             r_all_done;
   logic             w_accept;
   logic             w_tmo_hit;

   assign w_accept  = start && (num_jobs != '0);
   assign w_tmo_hit = (r_tmo_lat != '0) && (r_wait_cnt == r_tmo_lat);

   // An abort during the last GAP cycle must already steer to COMPLETE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (w_accept) w_next = S_LAUNCH;
         S_LAUNCH:   w_next = S_WAIT;
         S_WAIT: begin
            if (abort)          w_next = S_KILL;
            else if (done)      w_next = S_GAP;
            else if (w_tmo_hit) w_next = S_KILL;
         end
         S_KILL:     if (r_phase == KILL_LAST) w_next = S_GAP;
         S_GAP: begin
            if (r_phase == GAP_LAST)
               w_next = (abort || (r_left == '0)) ? S_COMPLETE : S_LAUNCH;
         end
         S_COMPLETE: w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_left     <= '0;
         r_ok_cnt   <= '0;
         r_tmo_cnt  <= '0;
         r_tmo_lat  <= '0;
         r_wait_cnt <= '0;
         r_phase    <= '0;
         r_go       <= 1'b0;
         r_kill     <= 1'b0;
         r_busy     <= 1'b0;
         r_all_done <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_go       <= (w_next == S_LAUNCH);
         r_kill     <= (w_next == S_KILL);
         r_busy     <= (w_next != S_IDLE);
         r_all_done <= (w_next == S_COMPLETE);

         if (w_next != r_state)
            r_phase <= '0;
         else if ((r_state == S_KILL) || (r_state == S_GAP))
            r_phase <= r_phase + 1'b1;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_left    <= num_jobs;
                  r_tmo_lat <= timeout;
                  r_ok_cnt  <= '0;
                  r_tmo_cnt <= '0;
               end
            end
            S_LAUNCH: r_wait_cnt <= '0;
            S_WAIT: begin
               if (abort) begin
                  r_left <= '0;
               end else if (done) begin
                  r_ok_cnt <= r_ok_cnt + 1'b1;
                  r_left   <= r_left - 1'b1;
               end else if (w_tmo_hit) begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  r_left    <= r_left - 1'b1;
               end else if (r_wait_cnt != '1) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            S_KILL, S_GAP: if (abort) r_left <= '0;
            default: ;
         endcase
      end
   end

   assign go       = r_go;
   assign kill     = r_kill;
   assign busy     = r_busy;
   assign all_done = r_all_done;
   assign ok_cnt   = r_ok_cnt;
   assign tmo_cnt  = r_tmo_cnt;

endmodule

// File: tb/tb_job_launcher.sv
// Directed self-checking bench for job_launcher with a small engine model
// that answers each go with a done after a programmable delay.
module tb_job_launcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       done;
   logic [3:0] numJobs;
   logic [7:0] timeoutVal;
   logic       go;
   logic       kill;
   logic       busy;
   logic       allDone;
   logic [3:0] okCnt;
   logic [3:0] tmoCnt;

   int checks   = 0;
   int failures = 0;

   int cyc           = 0;
   int goCnt         = 0;
   int goLong        = 0;
   int killCnt       = 0;
   int allDoneCnt    = 0;
   int busyLowAtDone = 0;
   int goCyc[64];
   int killStart[64];
   int killLen[64];
   int engineDelay   = 0;
   int lastGo        = -1000;
   logic prevGo      = 1'b0;
   logic prevKill    = 1'b0;

   int gb, kb, ab, lb;

   always #5 clk = ~clk;

   job_launcher #(
      .JOB_W(4), .TMO_W(8), .KILL_CYC(2), .GAP_CYC(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .num_jobs(numJobs),
      .timeout(timeoutVal),
      .abort(abort),
      .done(done),
      .go(go),
      .kill(kill),
      .busy(busy),
      .all_done(allDone),
      .ok_cnt(okCnt),
      .tmo_cnt(tmoCnt)
   );

   // Monitor and engine model, evaluated mid-cycle on the falling edge.
   initial begin
      done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (go) begin
            if (prevGo) goLong++;
            else begin
               goCyc[goCnt % 64] = cyc;
               goCnt++;
               lastGo = cyc;
            end
         end
         if (kill) begin
            if (!prevKill) begin
               killStart[killCnt % 64] = cyc;
               killLen[killCnt % 64]   = 0;
               killCnt++;
            end
            killLen[(killCnt - 1) % 64]++;
         end
         if (allDone) begin
            allDoneCnt++;
            if (!busy) busyLowAtDone++;
         end
         prevGo   = go;
         prevKill = kill;
         done = (engineDelay != 0) && (cyc == lastGo + engineDelay);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int n, input int t);
      numJobs    = 4'(n);
      timeoutVal = 8'(t);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic waitBatch(input int target, input int budget);
      int k = 0;
      while (allDoneCnt < target && k < budget) begin
         tick();
         k++;
      end
      if (allDoneCnt < target) checkOutput("waitBatch", allDoneCnt, target);
      tick();
      tick();
   endtask

   task automatic waitGo(input int target, input int budget);
      int k = 0;
      while (goCnt < target && k < budget) begin
         tick();
         k++;
      end
      if (goCnt < target) checkOutput("waitGo", goCnt, target);
   endtask

   task automatic snap();
      gb = goCnt;
      kb = killCnt;
      ab = allDoneCnt;
      lb = goLong;
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      numJobs    = '0;
      timeoutVal = '0;
      tick();
      tick();
      checkOutput("rstGo",      int'(go),      0);
      checkOutput("rstKill",    int'(kill),    0);
      checkOutput("rstBusy",    int'(busy),    0);
      checkOutput("rstAllDone", int'(allDone), 0);
      checkOutput("rstOk",      int'(okCnt),   0);
      checkOutput("rstTmo",     int'(tmoCnt),  0);
      reset = 1'b0;
      tick();

      $display("[TB] normal batch");
      snap();
      engineDelay = 102;
      applyStimulus(3, 200);
      waitBatch(ab + 1, 1000);
      checkOutput("nrmGoCnt",   goCnt - gb, 3);
      checkOutput("nrmGoWidth", goLong - lb, 0);
      checkOutput("nrmGap1",    goCyc[(gb + 1) % 64] - goCyc[gb % 64], 105);
      checkOutput("nrmGap2",    goCyc[(gb + 2) % 64] - goCyc[(gb + 1) % 64], 105);
      checkOutput("nrmKill",    killCnt - kb, 0);
      checkOutput("nrmAllDone", allDoneCnt - ab, 1);
      checkOutput("nrmOk",      int'(okCnt), 3);
      checkOutput("nrmTmo",     int'(tmoCnt), 0);
      checkOutput("nrmBusyEnd", int'(busy), 0);
      checkOutput("nrmBusyAtDone", busyLowAtDone, 0);

      $display("[TB] timeout batch");
      snap();
      engineDelay = 0;
      applyStimulus(2, 20);
      waitBatch(ab + 1, 500);
      checkOutput("tmoGoCnt",   goCnt - gb, 2);
      checkOutput("tmoKillCnt", killCnt - kb, 2);
      checkOutput("tmoKill1At", killStart[kb % 64] - goCyc[gb % 64], 22);
      checkOutput("tmoKill1Len", killLen[kb % 64], 2);
      checkOutput("tmoKill2At", killStart[(kb + 1) % 64] - goCyc[(gb + 1) % 64], 22);
      checkOutput("tmoKill2Len", killLen[(kb + 1) % 64], 2);
      checkOutput("tmoTmo",     int'(tmoCnt), 2);
      checkOutput("tmoOk",      int'(okCnt), 0);
      checkOutput("tmoAllDone", allDoneCnt - ab, 1);

      $display("[TB] done/timeout collision");
      snap();
      engineDelay = 11;
      applyStimulus(1, 10);
      waitBatch(ab + 1, 200);
      checkOutput("colOk",   int'(okCnt), 1);
      checkOutput("colTmo",  int'(tmoCnt), 0);
      checkOutput("colKill", killCnt - kb, 0);

      $display("[TB] abort in job 2");
      snap();
      engineDelay = 50;
      applyStimulus(5, 0);
      waitGo(gb + 2, 500);
      repeat (29) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      waitBatch(ab + 1, 500);
      checkOutput("abtGoCnt",   goCnt - gb, 2);
      checkOutput("abtKillCnt", killCnt - kb, 1);
      checkOutput("abtKillLen", killLen[kb % 64], 2);
      checkOutput("abtKillAt",  killStart[kb % 64] - goCyc[(gb + 1) % 64], 31);
      checkOutput("abtOk",      int'(okCnt), 1);
      checkOutput("abtTmo",     int'(tmoCnt), 0);
      checkOutput("abtAllDone", allDoneCnt - ab, 1);

      $display("[TB] ignored starts");
      snap();
      applyStimulus(0, 5);
      checkOutput("zeroGo",   int'(go), 0);
      tick();
      checkOutput("zeroBusy", int'(busy), 0);
      checkOutput("zeroGoCnt", goCnt - gb, 0);
      snap();
      engineDelay = 20;
      applyStimulus(2, 0);
      waitGo(gb + 1, 50);
      repeat (3) tick();
      numJobs    = 4'd7;
      timeoutVal = 8'd5;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      waitBatch(ab + 1, 300);
      checkOutput("midStartGoCnt", goCnt - gb, 2);
      checkOutput("midStartOk",    int'(okCnt), 2);
      checkOutput("midStartTmo",   int'(tmoCnt), 0);
      checkOutput("midStartKill",  killCnt - kb, 0);

      $display("[TB] reset during kill");
      snap();
      engineDelay = 0;
      applyStimulus(3, 4);
      begin
         int k = 0;
         while (killCnt < kb + 1 && k < 100) begin
            tick();
            k++;
         end
         if (killCnt < kb + 1) checkOutput("waitKill", killCnt - kb, 1);
      end
      reset = 1'b1;
      tick();
      checkOutput("midRstGo",      int'(go), 0);
      checkOutput("midRstKill",    int'(kill), 0);
      checkOutput("midRstBusy",    int'(busy), 0);
      checkOutput("midRstAllDone", int'(allDone), 0);
      checkOutput("midRstOk",      int'(okCnt), 0);
      checkOutput("midRstTmo",     int'(tmoCnt), 0);
      reset = 1'b0;
      tick();
      checkOutput("midRstNoPulse", allDoneCnt - ab, 0);
      snap();
      engineDelay = 5;
      applyStimulus(1, 0);
      waitBatch(ab + 1, 100);
      checkOutput("postRstGoCnt", goCnt - gb, 1);
      checkOutput("postRstOk",    int'(okCnt), 1);
      checkOutput("postRstTmo",   int'(tmoCnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
